input_debounce: RTL and testbench

//   Multi-channel debouncer for board switches and buttons (pause switch, reset button, etc.).

---
 rtl/input_debounce.sv | 136 +++++++++++++
 tb/tb_input_debounce.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// ============================================================================
// Module      : input_debounce
// Description : Multi-channel switch/button debouncer with clean level and
//               rise/fall pulses. Optional auto-repeat: DB_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce #(
    parameter int N_CH       = 2,
    parameter int DB_CYCLES  = 1000000,
    parameter int CNT_W      = 20,
    parameter int RPT_DELAY  = 50000000,
    parameter int RPT_PERIOD = 20000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic [N_CH-1:0] db_rpt
);

    localparam logic [0:0]       c_stable  = 1'b0;
    localparam logic [0:0]       c_pending = 1'b1;
    localparam logic [CNT_W-1:0] c_accept  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

`ifdef DB_REPEAT_EN
    localparam logic [CNT_W-1:0] c_rpt_delay  = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_rpt_period = CNT_W'(RPT_PERIOD - 1);
`else
    // Repeat timing is unused here; only the sanity of the values gates the tie-off.
    localparam logic c_rpt_cfg_ok = (RPT_DELAY > 0) && (RPT_PERIOD > 0);
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        logic [0:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_out;
        logic             r_rise;
        logic             r_fall;
        logic             w_diff;
        logic             w_accept;

        assign w_diff   = r_s2 ^ r_out;
        assign w_accept = (r_state == c_pending) && w_diff && (r_cnt == c_accept);

        // The first mismatch cycle is counted on entry to PENDING, so the
        // accept edge lands DB_CYCLES mismatch cycles after s2 changes.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_state <= c_stable;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_s1   <= raw_in[i];
                r_s2   <= r_s1;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                case (r_state)
                    c_stable: begin
                        if (w_diff) begin
                            r_state <= c_pending;
                            r_cnt   <= c_one;
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        if (!w_diff) begin
                            r_state <= c_stable;
                            r_cnt   <= '0;
                        end else if (w_accept) begin
                            r_out   <= r_s2;
                            r_rise  <= r_s2;
                            r_fall  <= ~r_s2;
                            r_state <= c_stable;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_one;
                        end
                    end
                endcase
            end
        end

        assign db_out[i]  = r_out;
        assign db_rise[i] = r_rise;
        assign db_fall[i] = r_fall;

`ifdef DB_REPEAT_EN
        logic [CNT_W-1:0] r_hold;
        logic             r_first_done;
        logic             r_rpt;

        // An accept while db_out is high is a fall: clear before any pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_hold       <= '0;
                r_first_done <= 1'b0;
                r_rpt        <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (!r_out || w_accept) begin
                    r_hold       <= '0;
                    r_first_done <= 1'b0;
                end else if (!r_first_done && (r_hold == c_rpt_delay)) begin
                    r_rpt        <= 1'b1;
                    r_hold       <= '0;
                    r_first_done <= 1'b1;
                end else if (r_first_done && (r_hold == c_rpt_period)) begin
                    r_rpt  <= 1'b1;
                    r_hold <= '0;
                end else begin
                    r_hold <= r_hold + c_one;
                end
            end
        end

        assign db_rpt[i] = r_rpt;
`else
        assign db_rpt[i] = 1'b0 & c_rpt_cfg_ok;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
// ============================================================================
// Module      : tb_input_debounce
// Description : Directed self-checking bench for input_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debounce;

    localparam int N_CH = 2;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] db_out;
    logic [N_CH-1:0] db_rise;
    logic [N_CH-1:0] db_fall;
    logic [N_CH-1:0] db_rpt;

    int n_checks;
    int n_pass;

    input_debounce #(
        .N_CH       (N_CH),
        .DB_CYCLES  (4),
        .CNT_W      (8),
        .RPT_DELAY  (10),
        .RPT_PERIOD (3)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_in),
        .db_out  (db_out),
        .db_rise (db_rise),
        .db_fall (db_fall),
        .db_rpt  (db_rpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [N_CH-1:0] val, input logic [N_CH-1:0] exp_out);
        raw_in = val;
        repeat (10) tick();
        check("settle db_out", 32'(db_out), 32'(exp_out));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        raw_in   = '0;
        repeat (3) tick();
        check("rst db_out",  32'(db_out),  32'h0);
        check("rst db_rise", 32'(db_rise), 32'h0);
        check("rst db_fall", 32'(db_fall), 32'h0);
        check("rst db_rpt",  32'(db_rpt),  32'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Clean press: tick j is edge k+j, db_out appears at k+5
        raw_in = 2'b01;
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("t1 db_out j=%0d", j),  32'(db_out),  (j >= 5) ? 32'h1 : 32'h0);
            check($sformatf("t1 db_rise j=%0d", j), 32'(db_rise), (j == 5) ? 32'h1 : 32'h0);
            check($sformatf("t1 db_fall j=%0d", j), 32'(db_fall), 32'h0);
        end

        // Glitch of 3 cycles from a low baseline
        settle(2'b00, 2'b00);
        raw_in = 2'b01;
        for (int j = 0; j < 12; j++) begin
            if (j == 3) raw_in = 2'b00;
            tick();
            check($sformatf("t2 db_out j=%0d", j),  32'(db_out),  32'h0);
            check($sformatf("t2 db_rise j=%0d", j), 32'(db_rise), 32'h0);
            check($sformatf("t2 db_fall j=%0d", j), 32'(db_fall), 32'h0);
        end

        // Bounce 1,0,1,0 then steady 1
        for (int j = 0; j < 4; j++) begin
            raw_in = (j % 2 == 0) ? 2'b01 : 2'b00;
            tick();
            check($sformatf("t3 bounce db_out j=%0d", j), 32'(db_out), 32'h0);
        end
        raw_in = 2'b01;
        begin
            int rises;
            rises = 0;
            for (int j = 0; j < 9; j++) begin
                tick();
                if (db_rise[0]) rises++;
                check($sformatf("t3 db_out j=%0d", j),  32'(db_out),  (j >= 5) ? 32'h1 : 32'h0);
                check($sformatf("t3 db_rise j=%0d", j), 32'(db_rise), (j == 5) ? 32'h1 : 32'h0);
            end
            check("t3 rise count", 32'(rises), 32'd1);
        end

        // Simultaneous: ch0 rises while ch1 falls
        settle(2'b10, 2'b10);
        raw_in = 2'b01;
        for (int j = 0; j < 8; j++) begin
            tick();
            check($sformatf("t4 db_out j=%0d", j),  32'(db_out),  (j >= 5) ? 32'h1 : 32'h2);
            check($sformatf("t4 db_rise j=%0d", j), 32'(db_rise), (j == 5) ? 32'h1 : 32'h0);
            check($sformatf("t4 db_fall j=%0d", j), 32'(db_fall), (j == 5) ? 32'h2 : 32'h0);
        end

        // Reset mid-count (cnt=2 on ch0) with ch1 already high
        settle(2'b10, 2'b10);
        raw_in = 2'b11;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check("t5 async db_out", 32'(db_out), 32'h0);
        for (int j = 0; j < 2; j++) begin
            tick();
            check($sformatf("t5 in-rst db_out j=%0d", j),  32'(db_out),  32'h0);
            check($sformatf("t5 in-rst db_rise j=%0d", j), 32'(db_rise), 32'h0);
            check($sformatf("t5 in-rst db_fall j=%0d", j), 32'(db_fall), 32'h0);
            check($sformatf("t5 in-rst db_rpt j=%0d", j),  32'(db_rpt),  32'h0);
        end
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check($sformatf("t5 db_out j=%0d", j),  32'(db_out),  (j >= 6) ? 32'h3 : 32'h0);
            check($sformatf("t5 db_rise j=%0d", j), 32'(db_rise), (j == 6) ? 32'h3 : 32'h0);
        end

        // Auto-repeat: rise at edge k+5, release sampled at k+25, fall at k+30
        settle(2'b00, 2'b00);
        raw_in = 2'b01;
        for (int t = 0; t <= 40; t++) begin
            logic [31:0] exp_rpt;
            if (t == 25) raw_in = 2'b00;
            tick();
`ifdef DB_REPEAT_EN
            exp_rpt = (t == 15 || t == 18 || t == 21 || t == 24 || t == 27) ? 32'h1 : 32'h0;
`else
            exp_rpt = 32'h0;
`endif
            check($sformatf("t6 db_rpt t=%0d", t), 32'(db_rpt), exp_rpt);
            if (t == 29 || t == 30)
                check($sformatf("t6 db_out t=%0d", t), 32'(db_out), (t == 29) ? 32'h1 : 32'h0);
            if (t == 30)
                check("t6 db_fall", 32'(db_fall), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
